// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encodings,
// default bus IDs and the byte-index width helper.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } fetch_state_e;

  localparam int AMID_PC_ID = 0;
  localparam int MID_MEM_ID = 4;
  localparam int SID_IR0_ID = 0;

  // A single-byte instruction still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: copies N_BYTES memory bytes at PC into the IR
// byte slots over the control bus, with wait states, abort and back-to-back fetch.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int N_BYTES     = 2,
  parameter int ID_W        = 5,
  parameter int AID_W       = 2,
  parameter int AMID_PC     = AMID_PC_ID,
  parameter int MID_MEM     = MID_MEM_ID,
  parameter int SID_IR_BASE = SID_IR0_ID
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             mem_ready,
  output logic [AID_W-1:0] AMID,
  output logic             AMID_EN,
  output logic [ID_W-1:0]  MID,
  output logic             MID_EN,
  output logic [ID_W-1:0]  SID,
  output logic             SID_EN,
  output logic             PC_INR,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = idx_width(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  if (N_BYTES < 1 || (SID_IR_BASE + N_BYTES - 1) >= (2 ** ID_W)) begin : g_param_check
    $error("fetch_sequencer: N_BYTES=%0d / SID_IR_BASE=%0d do not fit ID_W=%0d",
           N_BYTES, SID_IR_BASE, ID_W);
  end

  fetch_state_e     state_q, state_d;
  logic [IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [AID_W-1:0] amid_q, amid_d;
  logic [ID_W-1:0]  mid_q, mid_d, sid_q, sid_d;
  logic             amid_en_q, amid_en_d, mid_en_q, mid_en_d, sid_en_q, sid_en_d;
  logic             pc_inr_q, pc_inr_d, busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = SETUP;
          byte_idx_d = '0;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d    = IDLE;
          byte_idx_d = '0;
        end else if (mem_ready) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (abort) begin
          state_d    = IDLE;
          byte_idx_d = '0;
        end else if (byte_idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d    = SETUP;
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
      DONE: begin
        byte_idx_d = '0;
        state_d    = (start && !abort) ? SETUP : IDLE;
      end
      default: begin
        state_d    = IDLE;
        byte_idx_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // exactly with the state they describe in the following cycle.
  always_comb begin
    amid_d    = '0;
    amid_en_d = 1'b0;
    mid_d     = '0;
    mid_en_d  = 1'b0;
    sid_d     = '0;
    sid_en_d  = 1'b0;
    pc_inr_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_d)
      SETUP, LATCH: begin
        amid_d    = AID_W'(AMID_PC);
        amid_en_d = 1'b1;
        mid_d     = ID_W'(MID_MEM);
        mid_en_d  = 1'b1;
        sid_d     = ID_W'(SID_IR_BASE) + ID_W'(byte_idx_d);
        busy_d    = 1'b1;
        if (state_d == LATCH) begin
          sid_en_d = 1'b1;
          pc_inr_d = 1'b1;
        end
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      amid_q     <= '0;
      amid_en_q  <= 1'b0;
      mid_q      <= '0;
      mid_en_q   <= 1'b0;
      sid_q      <= '0;
      sid_en_q   <= 1'b0;
      pc_inr_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      amid_q     <= amid_d;
      amid_en_q  <= amid_en_d;
      mid_q      <= mid_d;
      mid_en_q   <= mid_en_d;
      sid_q      <= sid_d;
      sid_en_q   <= sid_en_d;
      pc_inr_q   <= pc_inr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign AMID    = amid_q;
  assign AMID_EN = amid_en_q;
  assign MID     = mid_q;
  assign MID_EN  = mid_en_q;
  assign SID     = sid_q;
  assign SID_EN  = sid_en_q;
  assign PC_INR  = pc_inr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a 2-byte instance and a 4-byte
// instance with IR base slot 2, checked cycle by cycle against queued vectors.
module tb_fetch_sequencer;

  typedef enum int {E_IDLE, E_SETUP, E_LATCH, E_DONE} exp_kind_e;

  logic clk = 1'b0;
  logic reset;
  logic start_a, abort_a, ready_a;
  logic start_b, abort_b, ready_b;

  logic [1:0] amid_a, amid_b;
  logic [4:0] mid_a, mid_b, sid_a, sid_b;
  logic       amid_en_a, mid_en_a, sid_en_a, pc_inr_a, busy_a, done_a;
  logic       amid_en_b, mid_en_b, sid_en_b, pc_inr_b, busy_b, done_b;

  logic [17:0] vec_a, vec_b, obs_vec;
  logic [17:0] exp_q[$];
  logic [17:0] exp_vec;
  int          sel;
  int          checks;
  int          failures;
  int          pc_total;
  int          pc_base;
  int          cycle_no;
  string       cur_test;

  always #5 clk = ~clk;

  fetch_sequencer #(.N_BYTES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a), .mem_ready(ready_a),
    .AMID(amid_a), .AMID_EN(amid_en_a), .MID(mid_a), .MID_EN(mid_en_a),
    .SID(sid_a), .SID_EN(sid_en_a), .PC_INR(pc_inr_a), .busy(busy_a), .done(done_a)
  );

  fetch_sequencer #(.N_BYTES(4), .SID_IR_BASE(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b), .mem_ready(ready_b),
    .AMID(amid_b), .AMID_EN(amid_en_b), .MID(mid_b), .MID_EN(mid_en_b),
    .SID(sid_b), .SID_EN(sid_en_b), .PC_INR(pc_inr_b), .busy(busy_b), .done(done_b)
  );

  assign vec_a = {amid_a, amid_en_a, mid_a, mid_en_a, sid_a, sid_en_a, pc_inr_a, busy_a, done_a};
  assign vec_b = {amid_b, amid_en_b, mid_b, mid_en_b, sid_b, sid_en_b, pc_inr_b, busy_b, done_b};
  assign obs_vec = (sel != 0) ? vec_b : vec_a;

  // Expected bus vector for a state: AMID=0, MID=4 while fetching, IDs 0 otherwise.
  function automatic logic [17:0] ev(input exp_kind_e k, input int sid);
    logic [4:0] s;
    s = 5'(sid);
    case (k)
      E_SETUP: ev = {2'd0, 1'b1, 5'd4, 1'b1, s, 1'b0, 1'b0, 1'b1, 1'b0};
      E_LATCH: ev = {2'd0, 1'b1, 5'd4, 1'b1, s, 1'b1, 1'b1, 1'b1, 1'b0};
      E_DONE:  ev = 18'h00001;
      default: ev = 18'h00000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%05h, expected 0x%05h", tag, observed, expected);
    end
  endtask

  // Pops one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_vec = exp_q.pop_front();
      cycle_no++;
      checkOutput($sformatf("%s_c%0d", cur_test, cycle_no), int'(obs_vec), int'(exp_vec));
      if (obs_vec[2]) pc_total++;
    end
  end

  // Drives one cycle of inputs for the selected instance and queues the
  // output vector expected after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic ab,
                               input logic rdy, input logic [17:0] expected);
    reset = rst;
    if (sel != 0) begin
      start_b = st; abort_b = ab; ready_b = rdy;
    end else begin
      start_a = st; abort_a = ab; ready_a = rdy;
    end
    exp_q.push_back(expected);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic beginTest(input string name);
    cur_test = name;
    cycle_no = 0;
    pc_base  = pc_total;
  endtask

  initial begin
    checks = 0; failures = 0; pc_total = 0; cycle_no = 0; sel = 0;
    reset = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;

    beginTest("reset");
    applyStimulus(1, 0, 0, 0, ev(E_IDLE, 0));
    applyStimulus(1, 0, 0, 0, ev(E_IDLE, 0));

    beginTest("basic");
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 0));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 0));
    applyStimulus(0, 0, 0, 1, ev(E_SETUP, 1));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 1));
    applyStimulus(0, 0, 0, 1, ev(E_DONE, 0));
    applyStimulus(0, 0, 0, 1, ev(E_IDLE, 0));
    checkOutput("basic_pc_inr", pc_total - pc_base, 2);

    beginTest("wait");
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 0));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 0));
    applyStimulus(0, 0, 0, 0, ev(E_SETUP, 1));
    applyStimulus(0, 0, 0, 0, ev(E_SETUP, 1));
    applyStimulus(0, 0, 0, 0, ev(E_SETUP, 1));
    applyStimulus(0, 0, 0, 0, ev(E_SETUP, 1));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 1));
    applyStimulus(0, 0, 0, 1, ev(E_DONE, 0));
    applyStimulus(0, 0, 0, 1, ev(E_IDLE, 0));
    checkOutput("wait_pc_inr", pc_total - pc_base, 2);

    beginTest("b2b");
    for (int n = 0; n < 2; n++) begin
      applyStimulus(0, 1, 0, 1, ev(E_SETUP, 0));
      applyStimulus(0, 1, 0, 1, ev(E_LATCH, 0));
      applyStimulus(0, 1, 0, 1, ev(E_SETUP, 1));
      applyStimulus(0, 1, 0, 1, ev(E_LATCH, 1));
      applyStimulus(0, 1, 0, 1, ev(E_DONE, 0));
    end
    applyStimulus(0, 0, 0, 1, ev(E_IDLE, 0));
    checkOutput("b2b_pc_inr", pc_total - pc_base, 4);

    beginTest("abort");
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 0));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 0));
    applyStimulus(0, 0, 0, 0, ev(E_SETUP, 1));
    applyStimulus(0, 0, 1, 1, ev(E_IDLE, 0));
    applyStimulus(0, 1, 1, 1, ev(E_IDLE, 0));
    applyStimulus(0, 0, 0, 1, ev(E_IDLE, 0));
    checkOutput("abort_pc_inr", pc_total - pc_base, 1);

    beginTest("abort_done");
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 0));
    applyStimulus(0, 1, 0, 1, ev(E_LATCH, 0));
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 1));
    applyStimulus(0, 1, 0, 1, ev(E_LATCH, 1));
    applyStimulus(0, 1, 0, 1, ev(E_DONE, 0));
    applyStimulus(0, 1, 1, 1, ev(E_IDLE, 0));
    applyStimulus(0, 0, 0, 1, ev(E_IDLE, 0));

    beginTest("reset_mid");
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 0));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 0));
    applyStimulus(0, 0, 0, 1, ev(E_SETUP, 1));
    applyStimulus(1, 1, 0, 1, ev(E_IDLE, 0));
    applyStimulus(1, 1, 0, 1, ev(E_IDLE, 0));
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 0));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 0));
    applyStimulus(0, 0, 0, 1, ev(E_SETUP, 1));
    applyStimulus(0, 0, 0, 1, ev(E_LATCH, 1));
    applyStimulus(0, 0, 0, 1, ev(E_DONE, 0));
    applyStimulus(0, 0, 0, 1, ev(E_IDLE, 0));

    sel = 1;
    beginTest("wide");
    applyStimulus(0, 1, 0, 1, ev(E_SETUP, 2));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 1, ev(E_LATCH, 2 + i));
      if (i < 3) applyStimulus(0, 0, 0, 1, ev(E_SETUP, 3 + i));
    end
    applyStimulus(0, 0, 0, 1, ev(E_DONE, 0));
    applyStimulus(0, 0, 0, 1, ev(E_IDLE, 0));
    checkOutput("wide_pc_inr", pc_total - pc_base, 4);

    checkOutput("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
